// File: rtl/mips_prog_loader.sv
`default_nettype none
// ============================================================================
// mips_prog_loader : host command port for the MIPS32 core (memory load,
//                    memory/register readback, run-until-halt with timeout)
// Revision 1.0
// ============================================================================
module mips_prog_loader #(
  parameter int MEM_DEPTH   = 1024,
  parameter int TIMEOUT_CYC = 4096,
  parameter int CNT_W       = 16,
  localparam int AW         = $clog2(MEM_DEPTH)
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [15:0]   cmd_addr,
  input  logic [31:0]   cmd_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_data,
  output logic [1:0]    rsp_status,
  output logic          mem_we,
  output logic          mem_re,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic [4:0]    reg_raddr,
  input  logic [31:0]   reg_rdata,
  output logic          cpu_clear,
  output logic          cpu_run,
  input  logic          cpu_halted
);

  localparam int LAW = (AW > 5) ? AW : 5;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WR     = 3'd1;
  localparam logic [2:0] S_RD_REQ = 3'd2;
  localparam logic [2:0] S_RD_CAP = 3'd3;
  localparam logic [2:0] S_REG    = 3'd4;
  localparam logic [2:0] S_CLR    = 3'd5;
  localparam logic [2:0] S_RUN    = 3'd6;
  localparam logic [2:0] S_RESP   = 3'd7;

  localparam logic [1:0] OP_MEM_WR = 2'b00;
  localparam logic [1:0] OP_MEM_RD = 2'b01;
  localparam logic [1:0] OP_REG_RD = 2'b10;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_BADADDR = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic             r_cmd_ready;
  logic [LAW-1:0]   r_addr;
  logic [31:0]      r_data;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_rsp_data;
  logic [1:0]       r_rsp_status;

  logic             w_accept;
  logic             w_bad;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_halt_seen;
  logic             w_timeout;

  assign w_accept = cmd_valid && r_cmd_ready;

  always_comb begin
    w_bad = 1'b0;
    if (cmd_op == OP_MEM_WR || cmd_op == OP_MEM_RD)
      w_bad = (int'(cmd_addr) >= MEM_DEPTH);
    else if (cmd_op == OP_REG_RD)
      w_bad = (cmd_addr > 16'd31);
  end

  // The counter is cleared in CLR, so zero marks the first RUN cycle, where a
  // Halted flag left over from the previous program must not end the run.
  assign w_cnt_inc   = (r_cnt == C_CNT_MAX) ? r_cnt : r_cnt + 1'b1;
  assign w_halt_seen = cpu_halted && (r_cnt != '0);
  assign w_timeout   = (w_cnt_inc >= C_TIMEOUT);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_bad) begin
            w_next = S_RESP;
          end else begin
            case (cmd_op)
              OP_MEM_WR: w_next = S_WR;
              OP_MEM_RD: w_next = S_RD_REQ;
              OP_REG_RD: w_next = S_REG;
              default:   w_next = S_CLR;
            endcase
          end
        end
      end
      S_WR:     w_next = S_RESP;
      S_RD_REQ: w_next = S_RD_CAP;
      S_RD_CAP: w_next = S_RESP;
      S_REG:    w_next = S_RESP;
      S_CLR:    w_next = S_RUN;
      S_RUN:    if (w_halt_seen || w_timeout) w_next = S_RESP;
      S_RESP:   if (rsp_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cmd_ready  <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_cnt        <= '0;
      r_rsp_data   <= '0;
      r_rsp_status <= ST_OK;
    end else begin
      r_state     <= w_next;
      // Registered so ready rises only in the cycle after a response retires.
      r_cmd_ready <= (w_next == S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr <= cmd_addr[LAW-1:0];
            r_data <= cmd_data;
            if (w_bad) begin
              r_rsp_data   <= '0;
              r_rsp_status <= ST_BADADDR;
            end
          end
        end
        S_WR: begin
          r_rsp_data   <= r_data;
          r_rsp_status <= ST_OK;
        end
        S_RD_CAP: begin
          r_rsp_data   <= mem_rdata;
          r_rsp_status <= ST_OK;
        end
        S_REG: begin
          r_rsp_data   <= reg_rdata;
          r_rsp_status <= ST_OK;
        end
        S_CLR: begin
          r_cnt <= '0;
        end
        S_RUN: begin
          r_cnt <= w_cnt_inc;
          if (w_halt_seen) begin
            r_rsp_data   <= 32'(w_cnt_inc);
            r_rsp_status <= ST_OK;
          end else if (w_timeout) begin
            r_rsp_data   <= 32'(C_TIMEOUT);
            r_rsp_status <= ST_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign rsp_valid  = (r_state == S_RESP);
  assign rsp_data   = r_rsp_data;
  assign rsp_status = r_rsp_status;

  assign mem_we    = (r_state == S_WR);
  assign mem_re    = (r_state == S_RD_REQ);
  assign mem_addr  = (r_state == S_WR || r_state == S_RD_REQ) ? r_addr[AW-1:0] : '0;
  assign mem_wdata = (r_state == S_WR) ? r_data : '0;
  assign reg_raddr = (r_state == S_REG) ? r_addr[4:0] : '0;
  assign cpu_clear = (r_state == S_CLR);
  assign cpu_run   = (r_state == S_RUN);

endmodule
`default_nettype wire

// File: tb/tb_mips_prog_loader.sv
`default_nettype none
// ============================================================================
// tb_mips_prog_loader : bench with memory, register bank and core stub models
// Revision 1.0
// ============================================================================
module tb_mips_prog_loader;

  localparam int T = 64;
  localparam logic [1:0] OP_WR = 2'b00, OP_RD = 2'b01, OP_REG = 2'b10, OP_RUN = 2'b11;
  localparam logic [1:0] ST_OK = 2'b00, ST_BAD = 2'b01, ST_TMO = 2'b10;

  logic        clk1 = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [15:0] cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_status;
  logic        mem_we, mem_re;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [4:0]  reg_raddr;
  logic [31:0] reg_rdata;
  logic        cpu_clear, cpu_run, cpu_halted;

  mips_prog_loader #(.MEM_DEPTH(1024), .TIMEOUT_CYC(T), .CNT_W(16)) dut (
    .clk1(clk1), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_status(rsp_status),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .reg_raddr(reg_raddr), .reg_rdata(reg_rdata),
    .cpu_clear(cpu_clear), .cpu_run(cpu_run), .cpu_halted(cpu_halted)
  );

  always #5 clk1 = ~clk1;

  // Environment: synchronous-read memory, combinational register bank, core stub.
  logic [31:0] env_mem [0:1023];
  logic [31:0] rdata_q = '0;
  logic [31:0] regs [0:31];
  int          run_k = 0;
  int          halt_at = 1000;
  logic        stale = 1'b0;

  always @(posedge clk1) begin
    if (mem_we) env_mem[mem_addr] <= mem_wdata;
    if (mem_re) rdata_q <= env_mem[mem_addr];
  end
  assign mem_rdata = rdata_q;
  assign reg_rdata = regs[reg_raddr];

  // Stub core: Halted is 'stale' in the first run cycle, then true from run cycle halt_at.
  always @(posedge clk1) begin
    if (cpu_clear) run_k <= 0;
    else if (cpu_run) run_k <= run_k + 1;
  end
  assign cpu_halted = (run_k == 0) ? stale : (run_k + 1 >= halt_at);

  int n_checks = 0;
  int n_err = 0;
  int viol = 0;

  always @(negedge clk1) begin
    if (cpu_run && (mem_we || mem_re || cpu_clear)) viol++;
    if (cmd_ready && rsp_valid) viol++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference for RUN: cycles = first cycle at which Halted counts (never cycle 1),
  // capped by the timeout; a halt landing exactly on the timeout cycle is OK.
  function automatic logic [31:0] run_cycles(input int h);
    int k;
    k = (h < 2) ? 2 : h;
    return (k <= T) ? 32'(k) : 32'(T);
  endfunction
  function automatic logic [1:0] run_status(input int h);
    int k;
    k = (h < 2) ? 2 : h;
    return (k <= T) ? ST_OK : ST_TMO;
  endfunction

  task automatic do_cmd(input logic [1:0] op, input logic [15:0] addr, input logic [31:0] data,
                        input int hold, output logic [31:0] d, output logic [1:0] s,
                        output int lat, output int we_n, output int re_n,
                        output int clr_n, output int run_n);
    int w;
    bit stable;
    w = 0;
    while (!cmd_ready && w < 100) begin @(negedge clk1); w++; end
    if (w >= 100) chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
    @(negedge clk1);
    cmd_valid = 1'b0;
    lat = 1; we_n = 0; re_n = 0; clr_n = 0; run_n = 0;
    forever begin
      we_n += int'(mem_we); re_n += int'(mem_re);
      clr_n += int'(cpu_clear); run_n += int'(cpu_run);
      if (rsp_valid || lat >= 500) break;
      @(negedge clk1);
      lat++;
    end
    if (!rsp_valid) chk("rsp_valid_wait", 32'(rsp_valid), 32'd1);
    d = rsp_data; s = rsp_status;
    stable = 1'b1;
    repeat (hold) begin
      @(negedge clk1);
      if (rsp_data !== d || rsp_status !== s || !rsp_valid || cmd_ready) stable = 1'b0;
    end
    if (hold > 0) chk("rsp_hold_stable", 32'(stable), 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk1);
    rsp_ready = 1'b0;
    chk("idle_after_rsp", 32'({cmd_ready, rsp_valid, cpu_run}), 32'b100);
  endtask

  task automatic run_check(input string tag, input logic [1:0] op, input logic [15:0] addr,
                           input logic [31:0] data, input logic [31:0] exp_d,
                           input logic [1:0] exp_s, input int hold);
    logic [31:0] d;
    logic [1:0]  s;
    int lat, we_n, re_n, clr_n, run_n, exp_lat;
    bit ok;
    do_cmd(op, addr, data, hold, d, s, lat, we_n, re_n, clr_n, run_n);
    ok = (exp_s == ST_OK);
    case (op)
      OP_WR:   exp_lat = ok ? 2 : 1;
      OP_RD:   exp_lat = ok ? 3 : 1;
      OP_REG:  exp_lat = ok ? 2 : 1;
      default: exp_lat = int'(exp_d) + 2;
    endcase
    chk({tag, "_data"}, d, exp_d);
    chk({tag, "_status"}, 32'(s), 32'(exp_s));
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_we_pulses"}, 32'(we_n), (op == OP_WR && ok) ? 32'd1 : 32'd0);
    chk({tag, "_re_pulses"}, 32'(re_n), (op == OP_RD && ok) ? 32'd1 : 32'd0);
    chk({tag, "_clear_pulses"}, 32'(clr_n), (op == OP_RUN) ? 32'd1 : 32'd0);
    chk({tag, "_run_cycles"}, 32'(run_n), (op == OP_RUN) ? exp_d : 32'd0);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [15:0] addr;
    logic [31:0] data;
    logic [31:0] exp_d;
    logic [1:0]  exp_s;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] op, input logic [15:0] addr,
                              input logic [31:0] data, input logic [31:0] exp_d,
                              input logic [1:0] exp_s);
    vec_t v;
    v.op = op; v.addr = addr; v.data = data; v.exp_d = exp_d; v.exp_s = exp_s;
    return v;
  endfunction

  logic [31:0] ref_mem [int];
  int          wr_q[$];
  vec_t        tbl[$];
  logic [31:0] prog [9] = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800,
                            32'h0ce77800, 32'h00222000, 32'h0ce77800, 32'h00832800,
                            32'hfc000000};

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  op;
    logic [15:0] addr;
    logic [31:0] data, exp_d;
    logic [1:0]  exp_s;
    int          w;

    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0] = 32'hdeadbeef;
    regs[1] = 32'd10; regs[2] = 32'd20; regs[3] = 32'd25; regs[4] = 32'd30; regs[5] = 32'd55;

    repeat (3) @(negedge clk1);
    chk("reset_ctrl", 32'({cmd_ready, rsp_valid, mem_we, mem_re, cpu_clear, cpu_run}), 32'd0);
    chk("reset_rsp", rsp_data | 32'(rsp_status), 32'd0);
    chk("reset_ports", 32'(mem_addr) | mem_wdata | 32'(reg_raddr), 32'd0);
    rst = 1'b0;
    @(negedge clk1);
    chk("ready_after_reset", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 9; i++) tbl.push_back(mk(OP_WR, 16'(i), prog[i], prog[i], ST_OK));
    tbl.push_back(mk(OP_RD,  16'd0,     0, 32'h2801000a, ST_OK));
    tbl.push_back(mk(OP_RD,  16'd8,     0, 32'hfc000000, ST_OK));
    tbl.push_back(mk(OP_WR,  16'd120,   85, 85, ST_OK));
    tbl.push_back(mk(OP_WR,  16'd200,   7, 7, ST_OK));
    tbl.push_back(mk(OP_RD,  16'd120,   0, 85, ST_OK));
    tbl.push_back(mk(OP_WR,  16'd1023,  32'ha5a5_0001, 32'ha5a5_0001, ST_OK));
    tbl.push_back(mk(OP_RD,  16'd1023,  0, 32'ha5a5_0001, ST_OK));
    tbl.push_back(mk(OP_WR,  16'd1024,  32'h1234_5678, 0, ST_BAD));
    tbl.push_back(mk(OP_RD,  16'd1023,  0, 32'ha5a5_0001, ST_OK));
    tbl.push_back(mk(OP_RD,  16'hffff,  0, 0, ST_BAD));
    tbl.push_back(mk(OP_REG, 16'd0,     0, 32'hdeadbeef, ST_OK));
    for (int i = 1; i <= 5; i++) tbl.push_back(mk(OP_REG, 16'(i), 0, regs[i], ST_OK));
    tbl.push_back(mk(OP_REG, 16'd31,    0, regs[31], ST_OK));
    tbl.push_back(mk(OP_REG, 16'd32,    0, 0, ST_BAD));
    tbl.push_back(mk(OP_REG, 16'd40,    0, 0, ST_BAD));

    foreach (tbl[i]) begin
      run_check($sformatf("vec%0d", i), tbl[i].op, tbl[i].addr, tbl[i].data,
                tbl[i].exp_d, tbl[i].exp_s, 0);
      if (tbl[i].op == OP_WR && tbl[i].exp_s == ST_OK) begin
        if (!ref_mem.exists(int'(tbl[i].addr))) wr_q.push_back(int'(tbl[i].addr));
        ref_mem[int'(tbl[i].addr)] = tbl[i].data;
      end
    end

    // RUN corner cases: normal halt, halt on the timeout cycle, one past it,
    // stale Halted ignored, no halt at all, and early halt.
    halt_at = 20;   stale = 1'b0; run_check("run_halt20", OP_RUN, 0, 0, 32'd20, ST_OK, 0);
    halt_at = T;    stale = 1'b0; run_check("run_halt_at_T", OP_RUN, 0, 0, 32'(T), ST_OK, 0);
    halt_at = T+1;  stale = 1'b0; run_check("run_halt_past_T", OP_RUN, 0, 0, 32'(T), ST_TMO, 0);
    halt_at = 1000; stale = 1'b1; run_check("run_stale", OP_RUN, 0, 0, 32'(T), ST_TMO, 0);
    halt_at = 1;    stale = 1'b1; run_check("run_early", OP_RUN, 0, 0, 32'd2, ST_OK, 0);
    chk("cpu_run_low_after_timeout", 32'(cpu_run), 32'd0);

    // Backpressure on an error response.
    run_check("bad_hold", OP_WR, 16'd1024, 32'hcafe, 0, ST_BAD, 5);

    // Reset ten cycles into a run.
    halt_at = 1000; stale = 1'b0;
    cmd_valid = 1'b1; cmd_op = OP_RUN; cmd_addr = '0; cmd_data = '0;
    @(negedge clk1);
    cmd_valid = 1'b0;
    w = 0;
    while (!cpu_run && w < 10) begin @(negedge clk1); w++; end
    chk("t6_run_started", 32'(cpu_run), 32'd1);
    repeat (9) @(negedge clk1);
    rst = 1'b1;
    @(negedge clk1);
    chk("t6_during_rst", 32'({cpu_run, rsp_valid, cmd_ready}), 32'd0);
    rst = 1'b0;
    @(negedge clk1);
    chk("t6_after_rst", 32'({cmd_ready, rsp_valid, cpu_run}), 32'b100);
    run_check("t6_reg3", OP_REG, 16'd3, 0, 32'd25, ST_OK, 0);

    // Randomized commands against the reference model.
    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom_range(0, 3));
      data = $urandom;
      case (op)
        OP_WR: begin
          addr = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(1024, 65535))
                                             : 16'($urandom_range(0, 1023));
          if (int'(addr) < 1024) begin
            exp_d = data; exp_s = ST_OK;
            if (!ref_mem.exists(int'(addr))) wr_q.push_back(int'(addr));
            ref_mem[int'(addr)] = data;
          end else begin
            exp_d = 0; exp_s = ST_BAD;
          end
        end
        OP_RD: begin
          if ($urandom_range(0, 7) != 0) begin
            addr = 16'(wr_q[$urandom_range(0, wr_q.size() - 1)]);
            exp_d = ref_mem[int'(addr)]; exp_s = ST_OK;
          end else begin
            addr = 16'($urandom_range(1024, 65535));
            exp_d = 0; exp_s = ST_BAD;
          end
        end
        OP_REG: begin
          addr = 16'($urandom_range(0, 40));
          exp_d = (addr > 16'd31) ? 32'd0 : regs[addr[4:0]];
          exp_s = (addr > 16'd31) ? ST_BAD : ST_OK;
        end
        default: begin
          addr = 16'($urandom);
          halt_at = $urandom_range(1, 90);
          stale = 1'($urandom_range(0, 1));
          exp_d = run_cycles(halt_at);
          exp_s = run_status(halt_at);
        end
      endcase
      run_check($sformatf("rand%0d", i), op, addr, data, exp_d, exp_s, $urandom_range(0, 3));
    end

    chk("strobe_or_overlap_violations", 32'(viol), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
